instr_fetch_unit: RTL

- Multi-cycle instruction fetch stage for the MIPS-32 core.
- Owns the PC register and issues one word request at a time to instruction memory.
- Captures the returned word and presents it to decode with a valid/ready handshake.
- Breaks out opcode and imm16 fields; out_imm16 feeds the LUI shift-left-by-16 path directly.

---
 rtl/mips_fetch_pkg.sv | 20 ++
 rtl/instr_fetch_unit_pc_reg.sv | 26 ++
 rtl/instr_fetch_unit.sv | 96 +++++++++
 3 files changed

// File: rtl/mips_fetch_pkg.sv
// Shared types and constants for the MIPS-32 instruction fetch stage.
package mips_fetch_pkg;

   typedef enum logic [1:0] {
      S_REQ  = 2'd0,
      S_WAIT = 2'd1,
      S_HOLD = 2'd2
   } fetch_state_t;

   localparam int INSTR_W  = 32;
   localparam int OPCODE_W = 6;
   localparam int IMM_W    = 16;

   localparam logic [31:0] PC_STEP_DEFAULT = 32'd4;

   function automatic logic [31:0] align_word(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/instr_fetch_unit_pc_reg.sv
// Program counter register: a redirect load wins over a sequential increment.
module pc_reg
   import mips_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] PC_STEP  = PC_STEP_DEFAULT
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        load,
   input  logic [31:0] load_pc,
   input  logic        inc,
   output logic [31:0] pc
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc <= RESET_PC;
      end else if (load) begin
         pc <= align_word(load_pc);
      end else if (inc) begin
         pc <= pc + PC_STEP;
      end
   end

endmodule

// File: rtl/instr_fetch_unit.sv
// Multi-cycle fetch stage: one outstanding imem request, result held for decode
// behind a valid/ready handshake.
module instr_fetch_unit
   import mips_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] PC_STEP  = PC_STEP_DEFAULT
) (
   input  logic                clk,
   input  logic                rst_n,
   output logic                imem_req,
   output logic [31:0]         imem_addr,
   input  logic                imem_ready,
   input  logic                imem_rvalid,
   input  logic [INSTR_W-1:0]  imem_rdata,
   input  logic                redirect_valid,
   input  logic [31:0]         redirect_pc,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [INSTR_W-1:0]  out_instr,
   output logic [31:0]         out_pc,
   output logic [OPCODE_W-1:0] out_opcode,
   output logic [IMM_W-1:0]    out_imm16
);

   fetch_state_t state;
   logic         drop;
   logic [31:0]  pc;
   logic         pc_inc;

   // The held instruction retires only from S_HOLD; a concurrent redirect still wins the PC.
   assign pc_inc = (state == S_HOLD) && out_valid && out_ready;

   pc_reg #(
      .RESET_PC(RESET_PC),
      .PC_STEP (PC_STEP)
   ) u_pc_reg (
      .clk    (clk),
      .rst_n  (rst_n),
      .load   (redirect_valid),
      .load_pc(redirect_pc),
      .inc    (pc_inc),
      .pc     (pc)
   );

   // Reset state is S_REQ, so the request is masked while reset is held.
   assign imem_req   = rst_n && (state == S_REQ);
   assign imem_addr  = pc;
   assign out_opcode = out_instr[INSTR_W-1 -: OPCODE_W];
   assign out_imm16  = out_instr[IMM_W-1:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_REQ;
         drop      <= 1'b0;
         out_valid <= 1'b0;
         out_instr <= '0;
         out_pc    <= '0;
      end else begin
         case (state)
            S_REQ: begin
               if (imem_ready) begin
                  state <= S_WAIT;
                  drop  <= redirect_valid;
               end
            end
            S_WAIT: begin
               // A response that coincides with a redirect belongs to the old path.
               if (imem_rvalid) begin
                  drop <= 1'b0;
                  if (!drop && !redirect_valid) begin
                     out_instr <= imem_rdata;
                     out_pc    <= pc;
                     out_valid <= 1'b1;
                     state     <= S_HOLD;
                  end else begin
                     state <= S_REQ;
                  end
               end else if (redirect_valid) begin
                  drop <= 1'b1;
               end
            end
            S_HOLD: begin
               if (redirect_valid || out_ready) begin
                  out_valid <= 1'b0;
                  state     <= S_REQ;
               end
            end
            default: begin
               state <= S_REQ;
            end
         endcase
      end
   end

endmodule
